// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one fetch per cycle into a
// 2-entry buffer drained by decode over valid/ready, with redirect/halt/fault.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        iClk,
  input  logic        iRstN,
  output logic [31:0] oImemAddr,
  input  logic [31:0] iImemInstr,
  output logic        oInstrValid,
  input  logic        iInstrReady,
  output logic [31:0] oInstr,
  output logic [31:0] oInstrPc,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc,
  input  logic        iHalt,
  output logic        oFault,
  output logic [31:0] oFetchCount
);

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;

  state_t      stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [1:0]  cntReg, cntNext;
  logic [31:0] fetchCountReg;
  logic [31:0] bufInstrReg [2];
  logic [31:0] bufPcReg    [2];
  logic [31:0] bufInstrNext[2];
  logic [31:0] bufPcNext   [2];

  logic       pcLegal;
  logic       bufFull;
  logic       pop;
  logic       fetch;
  logic [1:0] slot;

  assign pcLegal = (pcReg[1:0] == 2'b00) && (pcReg <= LAST_PC);
  assign bufFull = (cntReg == 2'd2);
  // Redirect wins over everything, so it suppresses both pop and fetch.
  assign pop     = oInstrValid && iInstrReady && !iRedirect;
  assign fetch   = !iRedirect && (stateReg == RUN) && !iHalt && pcLegal && (!bufFull || pop);
  assign slot    = cntReg - {1'b0, pop};

  always_comb begin
    stateNext    = stateReg;
    pcNext       = pcReg;
    cntNext      = cntReg;
    bufInstrNext = bufInstrReg;
    bufPcNext    = bufPcReg;
    if (iRedirect) begin
      pcNext    = iRedirectPc;
      cntNext   = 2'd0;
      stateNext = iHalt ? HALT : RUN;
    end else begin
      case (stateReg)
        RUN: begin
          if (iHalt)         stateNext = HALT;
          else if (!pcLegal) stateNext = FAULT;
        end
        HALT:    if (!iHalt) stateNext = RUN;
        FAULT:   stateNext = FAULT;
        default: stateNext = RUN;
      endcase
      if (pop) begin
        bufInstrNext[0] = bufInstrReg[1];
        bufPcNext[0]    = bufPcReg[1];
      end
      // After a pop the free slot is at the post-pop occupancy index.
      if (fetch) begin
        bufInstrNext[slot[0]] = iImemInstr;
        bufPcNext[slot[0]]    = pcReg;
        pcNext                = pcReg + 32'd4;
      end
      cntNext = slot + {1'b0, fetch};
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      stateReg      <= RUN;
      pcReg         <= RESET_PC;
      cntReg        <= 2'd0;
      fetchCountReg <= 32'd0;
    end else begin
      stateReg      <= stateNext;
      pcReg         <= pcNext;
      cntReg        <= cntNext;
      fetchCountReg <= fetchCountReg + {31'd0, pop};
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gBuf
    always_ff @(posedge iClk) begin
      bufInstrReg[gi] <= bufInstrNext[gi];
      bufPcReg[gi]    <= bufPcNext[gi];
    end
  end

  assign oImemAddr   = pcReg;
  assign oInstrValid = (cntReg != 2'd0);
  assign oInstr      = oInstrValid ? bufInstrReg[0] : 32'd0;
  assign oInstrPc    = oInstrValid ? bufPcReg[0] : 32'd0;
  assign oFault      = (stateReg == FAULT);
  assign oFetchCount = fetchCountReg;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios then random traffic, all
// checked each cycle against a queue-based reference model.
module tb_instr_fetch_ctrl;

  localparam int IMEM_BYTES = 1024;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic [31:0] oImemAddr;
  logic [31:0] iImemInstr;
  logic        oInstrValid;
  logic        iInstrReady;
  logic [31:0] oInstr;
  logic [31:0] oInstrPc;
  logic        iRedirect;
  logic [31:0] iRedirectPc;
  logic        iHalt;
  logic        oFault;
  logic [31:0] oFetchCount;

  instr_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM_BYTES)) dut (
    .iClk(iClk), .iRstN(iRstN), .oImemAddr(oImemAddr), .iImemInstr(iImemInstr),
    .oInstrValid(oInstrValid), .iInstrReady(iInstrReady), .oInstr(oInstr),
    .oInstrPc(oInstrPc), .iRedirect(iRedirect), .iRedirectPc(iRedirectPc),
    .iHalt(iHalt), .oFault(oFault), .oFetchCount(oFetchCount)
  );

  always #5 iClk = ~iClk;

  logic [31:0] mem [IMEM_BYTES/4];
  assign iImemInstr = (oImemAddr < 32'(IMEM_BYTES)) ? mem[oImemAddr[9:2]] : 32'hBAD0_BAD0;

  // Reference model: PC, mode (0 run, 1 halt, 2 fault), queue of {pc, instr}.
  logic [31:0] mPc;
  int          mMode;
  logic [63:0] mQ[$];
  logic [31:0] mCount;

  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic rst, input logic rdy, input logic hlt,
                           input logic rdr, input logic [31:0] rpc);
    bit legal, popNow, fetchNow;
    if (!rst) begin
      mPc = 32'h0; mMode = 0; mQ.delete(); mCount = 0;
    end else if (rdr) begin
      mQ.delete(); mPc = rpc; mMode = hlt ? 1 : 0;
    end else begin
      legal    = (mPc % 4 == 0) && (mPc <= IMEM_BYTES - 4);
      popNow   = (mQ.size() > 0) && rdy;
      fetchNow = (mMode == 0) && !hlt && legal && (mQ.size() < 2 || popNow);
      if (popNow) begin
        void'(mQ.pop_front());
        mCount++;
      end
      if (fetchNow) begin
        mQ.push_back({mPc, mem[mPc / 4]});
        mPc += 4;
      end
      if (mMode == 0)      mMode = hlt ? 1 : (legal ? 0 : 2);
      else if (mMode == 1) mMode = hlt ? 1 : 0;
    end
  endtask

  task automatic checkAll();
    logic [63:0] head;
    head = (mQ.size() > 0) ? mQ[0] : 64'd0;
    checkVal("addr",  oImemAddr, mPc);
    checkVal("valid", {31'd0, oInstrValid}, {31'd0, mQ.size() > 0});
    checkVal("instr", oInstr, head[31:0]);
    checkVal("pc",    oInstrPc, head[63:32]);
    checkVal("fault", {31'd0, oFault}, {31'd0, mMode == 2});
    checkVal("count", oFetchCount, mCount);
  endtask

  // Called at a negedge: drive, advance model, cross one rising edge, check.
  task automatic step(input logic rst, input logic rdy, input logic hlt,
                      input logic rdr, input logic [31:0] rpc);
    iRstN = rst; iInstrReady = rdy; iHalt = hlt; iRedirect = rdr; iRedirectPc = rpc;
    modelStep(rst, rdy, hlt, rdr, rpc);
    @(posedge iClk);
    @(negedge iClk);
    checkAll();
  endtask

  logic halted;
  logic [31:0] rpc;

  initial begin
    for (int i = 0; i < IMEM_BYTES / 4; i++) mem[i] = $urandom;
    mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
    iRstN = 1'b0; iInstrReady = 1'b0; iHalt = 1'b0; iRedirect = 1'b0; iRedirectPc = 32'h0;
    @(negedge iClk);

    // Reset, then streaming with ready held high.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    checkVal("rst_valid", {31'd0, oInstrValid}, 32'd0);
    checkVal("rst_addr",  oImemAddr, 32'h0);
    checkVal("rst_count", oFetchCount, 32'd0);
    step(1, 1, 0, 0, 0);
    checkVal("first_pc",    oInstrPc, 32'h0);
    checkVal("first_instr", oInstr, 32'h1111_1111);
    step(1, 1, 0, 0, 0);
    checkVal("second_pc", oInstrPc, 32'h4);
    step(1, 1, 0, 0, 0);
    checkVal("third_pc", oInstrPc, 32'h8);
    step(1, 1, 0, 0, 0);
    checkVal("count_3", oFetchCount, 32'd3);

    // Backpressure from reset: buffer fills with 0 and 4, PC holds at 8.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    checkVal("bp_addr",  oImemAddr, 32'h8);
    checkVal("bp_instr", oInstr, 32'h1111_1111);
    step(1, 1, 0, 0, 0);
    checkVal("bp_rel_pc",  oInstrPc, 32'h4);
    step(1, 1, 0, 0, 0);
    checkVal("bp_nobubble", oInstrPc, 32'h8);

    // Redirect while the buffer is full.
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 32'h40);
    checkVal("rd_count", oFetchCount, 32'd0);
    checkVal("rd_valid", {31'd0, oInstrValid}, 32'd0);
    step(1, 1, 0, 0, 0);
    checkVal("rd_pc", oInstrPc, 32'h40);

    // Misaligned and out-of-range targets fault; a legal redirect recovers.
    step(1, 1, 0, 1, 32'h3FE);
    step(1, 1, 0, 0, 0);
    checkVal("fault_3fe", {31'd0, oFault}, 32'd1);
    step(1, 1, 0, 1, 32'h400);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checkVal("fault_400", {31'd0, oFault}, 32'd1);
    step(1, 1, 0, 1, 32'h10);
    checkVal("fault_clr", {31'd0, oFault}, 32'd0);
    step(1, 1, 0, 0, 0);
    checkVal("resume_pc", oInstrPc, 32'h10);

    // Halt for 3 cycles at 0x20, and halt combined with redirect.
    step(1, 1, 0, 1, 32'h20);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
    checkVal("halt_addr", oImemAddr, 32'h20);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 32'h80);
    step(1, 1, 1, 0, 0);
    checkVal("halt_rd_addr", oImemAddr, 32'h80);
    step(1, 1, 0, 0, 0);

    // Random traffic.
    halted = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) halted = ~halted;
      rpc = 32'h0;
      case ($urandom_range(0, 7))
        5:       rpc = 32'h3FE;
        6:       rpc = 32'h400;
        7:       rpc = 32'h3FC;
        default: rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      endcase
      step($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, halted,
           $urandom_range(0, 15) == 0, rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
